// File: rtl/keccak_e_feeder.sv
// -----------------------------------------------------------------------------
// keccak_e_feeder
//
// Purpose: upstream stage of the SHA3/Keccak core in the ROLLO encrypt
// datapath. Reads the error vector E from a word-addressed memory, packs pairs
// of 32-bit memory words into 64-bit Keccak input words (first byte in
// k_in[63:56]) and hands them to the core, honouring its buffer_full
// backpressure. The last word always carries k_is_last and the number of valid
// bytes; it is empty (k_in = 0, byte_num = 0) when the length is a multiple of
// eight. Keccak padding stays inside the core.
//
// Optional feature: define KFEED_PREFIX_EN to add the k_prefix input; a full
// 64-bit prefix word is then sent ahead of the E words.
//
// Ports:
//   clk            system clock, rising edge
//   rst_b          synchronous reset, active-high (asserted = 1)
//   start          one-cycle request to begin streaming (only honoured in IDLE)
//   mem_rd         memory read enable
//   mem_addr       memory read address
//   mem_dout       read data, valid exactly one cycle after mem_rd
//   k_prefix       prefix word (KFEED_PREFIX_EN only)
//   k_in           Keccak input word
//   k_in_ready     k_in valid
//   k_is_last      marks the final (possibly partial or empty) word
//   k_byte_num     valid bytes in the final word, 0 on other words
//   k_buffer_full  Keccak core cannot accept a word this cycle
//   busy           high from accepted start until done
//   done           one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module keccak_e_feeder #(
  parameter int MEM_W     = 32,   // must be 32: two memory words per Keccak word
  parameter int AW        = 8,
  parameter int LEN_BYTES = 13,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [MEM_W-1:0] mem_dout,
`ifdef KFEED_PREFIX_EN
  input  logic [63:0]      k_prefix,
`endif
  output logic [63:0]      k_in,
  output logic             k_in_ready,
  output logic             k_is_last,
  output logic [2:0]       k_byte_num,
  input  logic             k_buffer_full,
  output logic             busy,
  output logic             done
);

`ifdef KFEED_PREFIX_EN
  localparam int PFX = 1;
`else
  localparam int PFX = 0;
`endif
  localparam int NW   = LEN_BYTES / 8;   // full E words
  localparam int TAIL = LEN_BYTES % 8;   // bytes in the terminal word
  localparam int TW   = PFX + NW + 1;    // words presented per stream
  localparam int CW   = AW + 1;

  localparam logic [CW-1:0] LAST_IDX  = CW'(TW - 1);
  localparam logic [2:0]    TAIL_B    = 3'(TAIL);
  // Keeps the top TAIL bytes of the terminal word; all zero for an empty one.
  localparam logic [63:0]   LAST_MASK = (TAIL == 0) ? 64'd0
                                      : ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * TAIL));

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI, S_RD_LO, S_CAP, S_PRESENT, S_DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    wcnt_q;       // index of the word being fetched/presented
  logic [AW-1:0]    addr_q;       // next memory address to read
  logic [MEM_W-1:0] hi_q;
  logic             mem_rd_q;
  logic [AW-1:0]    mem_addr_q;
  logic [63:0]      k_in_q;
  logic             k_in_ready_q;
  logic             k_is_last_q;
  logic [2:0]       k_byte_num_q;
  logic             busy_q;
  logic             done_q;

  logic [CW-1:0]    nxt_idx_d;
  logic [MEM_W-1:0] lo_d;
  logic [63:0]      word_d;

  function automatic logic is_last_f(input logic [CW-1:0] idx);
    return idx == LAST_IDX;
  endfunction

  function automatic logic is_pfx_f(input logic [CW-1:0] idx);
    return (PFX != 0) && (idx == '0);
  endfunction

  // High half is needed unless this is the prefix or an empty terminal word.
  function automatic logic need_hi_f(input logic [CW-1:0] idx);
    return !is_pfx_f(idx) && (!is_last_f(idx) || (TAIL != 0));
  endfunction

  // Low half is skipped when the terminal word fits in the high half.
  function automatic logic need_lo_f(input logic [CW-1:0] idx);
    return !is_pfx_f(idx) && (!is_last_f(idx) || (TAIL > 4));
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nxt_idx_d = wcnt_q + 1'b1;
    lo_d      = need_lo_f(wcnt_q) ? mem_dout : '0;
    word_d    = {hi_q, lo_d} & (is_last_f(wcnt_q) ? LAST_MASK : 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef KFEED_PREFIX_EN
    if (is_pfx_f(wcnt_q)) word_d = k_prefix;
`endif
  end

  // Every state word is a register, word on every cycle walks
  // RD_HI -> RD_LO -> CAP -> PRESENT, with reads suppressed where not needed,
  // which also keeps presentations at least three cycles after an acceptance.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      // NOTE: every register, including the data holding ones, is reset so
      // that all outputs read zero right after reset.
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      addr_q       <= '0;
      hi_q         <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      k_in_q       <= '0;
      k_in_ready_q <= 1'b0;
      k_is_last_q  <= 1'b0;
      k_byte_num_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RD_HI;
            busy_q     <= 1'b1;
            wcnt_q     <= '0;
            mem_rd_q   <= need_hi_f('0);
            mem_addr_q <= AW'(BASE_ADDR);
            addr_q     <= AW'(BASE_ADDR) + AW'(need_hi_f('0));
          end
        end
        S_RD_HI: begin
          state_q    <= S_RD_LO;
          mem_rd_q   <= need_lo_f(wcnt_q);
          mem_addr_q <= addr_q;
          addr_q     <= addr_q + AW'(need_lo_f(wcnt_q));
        end
        S_RD_LO: begin
          hi_q     <= mem_dout;   // high-half data returns this cycle
          mem_rd_q <= 1'b0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          k_in_q       <= word_d;
          k_in_ready_q <= 1'b1;
          k_is_last_q  <= is_last_f(wcnt_q);
          k_byte_num_q <= is_last_f(wcnt_q) ? TAIL_B : 3'd0;
          state_q      <= S_PRESENT;
        end
        S_PRESENT: begin
          // Outputs hold untouched while the core reports buffer_full.
          if (!k_buffer_full) begin
            k_in_ready_q <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= '0;
            if (k_is_last_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= S_RD_HI;
              wcnt_q     <= nxt_idx_d;
              mem_rd_q   <= need_hi_f(nxt_idx_d);
              mem_addr_q <= addr_q;
              addr_q     <= addr_q + AW'(need_hi_f(nxt_idx_d));
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign k_in       = k_in_q;
  assign k_in_ready = k_in_ready_q;
  assign k_is_last  = k_is_last_q;
  assign k_byte_num = k_byte_num_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
